// File: rtl/upsample_layer.sv
// Nearest-neighbour upsampler: repeats each pixel Scale times across, and replays each
// buffered row Scale times down, with valid/ready handshakes on both sides.
//
// state     | meaning
// ST_FILL   | rep_y==0: accept input pixels, store them in line_buf and emit them
// ST_REPLAY | rep_y>0: input stalled, re-emit the buffered row from line_buf
module upsample_layer #(
   parameter int unsigned LineWidthPx = 80,
   parameter int unsigned LineCountPx = 60,
   parameter int unsigned Width       = 32,
   parameter int unsigned Channels    = 1,
   parameter int unsigned Scale       = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic [Channels-1:0][Width-1:0]     data_i,
   output logic                               valid_o,
   input  logic                               ready_i,
   output logic [Channels-1:0][Width-1:0]     data_o,
   output logic                               last_o
);

   localparam int unsigned XW = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
   localparam int unsigned YW = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
   localparam int unsigned RW = (Scale > 1) ? $clog2(Scale) : 1;

   localparam logic [XW-1:0] XMax = XW'(LineWidthPx - 1);
   localparam logic [YW-1:0] YMax = YW'(LineCountPx - 1);
   localparam logic [RW-1:0] RMax = RW'(Scale - 1);

   typedef logic [Channels-1:0][Width-1:0] pix_t;
   typedef enum logic {ST_FILL, ST_REPLAY} state_e;

   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [RW-1:0] rep_x_q, rep_x_d;
   logic [RW-1:0] rep_y_q, rep_y_d;
   logic          valid_q, valid_d;
   logic          tag_last_q, tag_last_d;
   pix_t          data_q, data_d;

   pix_t line_buf [LineWidthPx];

   logic out_fire;
   logic slot_free;
   logic load;
   logic buf_we;
   logic x_end, y_end, ry_end;
   pix_t src;

   always_comb begin
      out_fire  = valid_q & ready_i;
      slot_free = ~valid_q | (out_fire & (rep_x_q == RMax));
      x_end     = (x_q == XMax);
      y_end     = (y_q == YMax);
      ry_end    = (rep_y_q == RMax);

      ready_o = 1'b0;
      load    = 1'b0;
      buf_we  = 1'b0;
      src     = line_buf[x_q];
      if (state_q == ST_FILL) begin
         ready_o = slot_free;
         load    = valid_i & slot_free;
         buf_we  = valid_i & slot_free;
         src     = data_i;
      end else begin
         load = slot_free;
      end

      x_d        = x_q;
      y_d        = y_q;
      rep_x_d    = rep_x_q;
      rep_y_d    = rep_y_q;
      valid_d    = valid_q;
      tag_last_d = tag_last_q;
      data_d     = data_q;
      state_d    = state_q;

      if (load) begin
         data_d     = src;
         valid_d    = 1'b1;
         rep_x_d    = '0;
         tag_last_d = x_end & y_end & ry_end;
         x_d        = x_end ? '0 : x_q + 1'b1;
         if (x_end) begin
            if (ry_end) begin
               rep_y_d = '0;
               y_d     = y_end ? '0 : y_q + 1'b1;
            end else begin
               rep_y_d = rep_y_q + 1'b1;
            end
         end
         state_d = (rep_y_d != '0) ? ST_REPLAY : ST_FILL;
      end else if (slot_free) begin
         valid_d = 1'b0;
      end else if (out_fire) begin
         rep_x_d = rep_x_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_FILL;
         x_q        <= '0;
         y_q        <= '0;
         rep_x_q    <= '0;
         rep_y_q    <= '0;
         valid_q    <= 1'b0;
         tag_last_q <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         rep_x_q    <= rep_x_d;
         rep_y_q    <= rep_y_d;
         valid_q    <= valid_d;
         tag_last_q <= tag_last_d;
         data_q     <= data_d;
      end
   end

   // Buffer contents are don't-care after reset; only FILL writes, only REPLAY reads.
   always_ff @(posedge clk_i) begin
      if (buf_we) begin
         line_buf[x_q] <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = valid_q & (rep_x_q == RMax) & tag_last_q;

endmodule

// File: tb/tb_upsample_layer.sv
// Bench for upsample_layer: a Scale=2 and a Scale=1 instance on a 4x2 frame, checked
// against a row-level expected-stream model plus hand-written literal sequences.
module tb_upsample_layer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int T1 [32] = '{0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3,
                              4,4,5,5,6,6,7,7, 4,4,5,5,6,6,7,7};

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vi [2];
   logic        ro [2];
   logic        vo [2];
   logic        ri [2];
   logic        lo [2];
   logic [31:0] di [2];
   logic [31:0] dout [2];
   bit          rnd_rdy [2];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          in_idx [2];
   bit          hold [2];
   logic [31:0] hold_d [2];
   logic        hold_l [2];

   exp_t        expq [2][$];
   logic [31:0] row_buf [2][$];
   logic [31:0] log_d [2][$];
   bit          log_l [2][$];
   bit          log_r [2][$];
   int          log_c [2][$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      upsample_layer #(
         .LineWidthPx(W), .LineCountPx(H), .Width(32), .Channels(1),
         .Scale((g == 0) ? 2 : 1)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .valid_i(vi[g]), .ready_o(ro[g]), .data_i(di[g]),
         .valid_o(vo[g]), .ready_i(ri[g]), .data_o(dout[g]), .last_o(lo[g])
      );
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Expected stream: each pixel Scale times at once, then the whole row again Scale-1 times.
   function automatic void model_push(int g, logic [31:0] d);
      int   s;
      bool_last_t: begin end
      s = (g == 0) ? 2 : 1;
      row_buf[g].push_back(d);
      for (int c = 0; c < s; c++) begin
         exp_t e;
         e.d = d;
         e.l = (s == 1) && (in_idx[g] == W*H-1);
         expq[g].push_back(e);
      end
      if (in_idx[g] % W == W-1) begin
         for (int r = 1; r < s; r++)
            for (int p = 0; p < W; p++)
               for (int c = 0; c < s; c++) begin
                  exp_t e;
                  e.d = row_buf[g][p];
                  e.l = (in_idx[g] == W*H-1) && (r == s-1) && (p == W-1) && (c == s-1);
                  expq[g].push_back(e);
               end
         row_buf[g].delete();
      end
      in_idx[g] = (in_idx[g] + 1) % (W*H);
   endfunction

   initial begin
      in_idx = '{0, 0};
      hold   = '{0, 0};
      forever begin
         @(negedge clk);
         cyc++;
         for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
               expq[g].delete();
               row_buf[g].delete();
               in_idx[g] = 0;
               hold[g]   = 1'b0;
            end else begin
               if (hold[g]) begin
                  chk("hold_valid", 32'(vo[g]), 32'd1);
                  chk("hold_data", dout[g], hold_d[g]);
                  chk("hold_last", 32'(lo[g]), 32'(hold_l[g]));
               end
               if (vo[g] && ri[g]) begin
                  if (expq[g].size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL extra_beat dut%0d actual=%0h required=none", g, dout[g]);
                  end else begin
                     exp_t e;
                     e = expq[g].pop_front();
                     chk("out_data", dout[g], e.d);
                     chk("out_last", 32'(lo[g]), 32'(e.l));
                  end
                  log_d[g].push_back(dout[g]);
                  log_l[g].push_back(lo[g]);
                  log_r[g].push_back(ro[g]);
                  log_c[g].push_back(cyc);
               end
               if (vi[g] && ro[g]) model_push(g, di[g]);
               hold[g]   = vo[g] && !ri[g];
               hold_d[g] = dout[g];
               hold_l[g] = lo[g];
            end
         end
      end
   end

   initial begin
      ri = '{1'b1, 1'b1};
      forever begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) ri[g] = rnd_rdy[g] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_px(int g, logic [31:0] d, bit rnd);
      bit acc;
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      vi[g] = 1'b1;
      di[g] = d;
      acc   = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = ro[g];
         @(posedge clk);
         #1;
      end
      vi[g] = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(int g, int base, bit rnd);
      for (int i = 0; i < W*H; i++) send_px(g, 32'(base + i), rnd);
   endtask

   task automatic drain(int g);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         #1;
         if (expq[g].size() == 0 && !vo[g]) break;
      end
      chk("drain", 32'(expq[g].size() == 0 && !vo[g]), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_t1(string tag, int s, int n);
      for (int i = 0; i < n; i++)
         if (s + i < log_d[0].size()) begin
            chk({tag, "_data"}, log_d[0][s+i], 32'(T1[i]));
            chk({tag, "_last"}, 32'(log_l[0][s+i]), 32'(i == 31));
         end
   endtask

   initial begin
      int s;
      int nl;
      vi = '{1'b0, 1'b0};
      di = '{32'd0, 32'd0};
      rnd_rdy = '{1'b0, 1'b0};
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("rst_valid", 32'(vo[g]), 32'd0);
         chk("rst_data", dout[g], 32'd0);
         chk("rst_last", 32'(lo[g]), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Scale=2, ready_i held high
      s = log_d[0].size();
      send_frame(0, 0, 1'b0);
      drain(0);
      chk("t1_beats", 32'(log_d[0].size() - s), 32'd32);
      check_t1("t1", s, 32);
      if (log_d[0].size() >= s + 32)
         chk("t1_contig", 32'(log_c[0][s+31] - log_c[0][s]), 32'd31);

      // Same frame, random valid_i gaps and ready_i
      rnd_rdy[0] = 1'b1;
      s = log_d[0].size();
      send_frame(0, 0, 1'b1);
      drain(0);
      rnd_rdy[0] = 1'b0;
      chk("t2_beats", 32'(log_d[0].size() - s), 32'd32);
      check_t1("t2", s, 32);

      // Scale=1: one-cycle latency, pass-through
      s = log_d[1].size();
      vi[1] = 1'b1;
      di[1] = 32'd100;
      @(negedge clk);
      chk("t4_ready", 32'(ro[1]), 32'd1);
      @(posedge clk);
      #1;
      vi[1] = 1'b0;
      @(negedge clk);
      chk("t4_lat_valid", 32'(vo[1]), 32'd1);
      chk("t4_lat_data", dout[1], 32'd100);
      @(posedge clk);
      #1;
      for (int i = 1; i < W*H; i++) send_px(1, 32'(100 + i), 1'b0);
      drain(1);
      chk("t4_beats", 32'(log_d[1].size() - s), 32'd8);
      for (int i = 0; i < 8; i++)
         if (s + i < log_d[1].size()) begin
            chk("t4_data", log_d[1][s+i], 32'(100 + i));
            chk("t4_last", 32'(log_l[1][s+i]), 32'(i == 7));
         end
      if (log_d[1].size() >= s + 8)
         chk("t4_rate", 32'(log_c[1][s+7] - log_c[1][s+1]), 32'd6);

      // Reset after five output beats
      s = log_d[0].size();
      for (int i = 0; i < 3; i++) send_px(0, 32'(i), 1'b0);
      for (int t = 0; t < 50 && log_d[0].size() < s + 5; t++) begin
         @(negedge clk);
         #1;
      end
      chk("t5_five_beats", 32'(log_d[0].size() >= s + 5), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(vo[0]), 32'd0);
      chk("t5_async_last", 32'(lo[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      s = log_d[0].size();
      send_frame(0, 0, 1'b0);
      drain(0);
      chk("t5_beats", 32'(log_d[0].size() - s), 32'd32);
      check_t1("t5", s, 32);

      // Two frames back to back, ready_i high
      s = log_d[0].size();
      send_frame(0, 0, 1'b0);
      send_frame(0, 8, 1'b0);
      drain(0);
      chk("t6_beats", 32'(log_d[0].size() - s), 32'd64);
      if (log_d[0].size() >= s + 64) begin
         chk("t6_contig", 32'(log_c[0][s+63] - log_c[0][s]), 32'd63);
         nl = 0;
         for (int i = 0; i < 64; i++) nl += int'(log_l[0][s+i]);
         chk("t6_last_count", 32'(nl), 32'd2);
         chk("t6_last_32", 32'(log_l[0][s+31]), 32'd1);
         chk("t6_last_64", 32'(log_l[0][s+63]), 32'd1);
         chk("t6_f2_first", log_d[0][s+32], 32'd8);
         for (int r = 0; r < 4; r++)
            for (int b = 8; b < 15; b++)
               chk("t6_replay_ready", 32'(log_r[0][s + r*16 + b]), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
